// File: rtl/genius_controle_vidas.sv
`default_nettype none
// ============================================================================
//  Module      : genius_controle_vidas
//  Description : Memory-game controller with lives. Owns the address, round,
//                show and move timers, drives an external synchronous
//                sequence RAM and judges one-hot button moves. A wrong move
//                or a move timeout costs one life and replays the same round.
//                In modo2 the player appends the next sequence element after
//                each completed round.
//  Ports       : clock, reset (async, active low), iniciar, botoes, modo2,
//                nivel_rodadas, mem_rdata | mem_addr, mem_we, mem_wdata,
//                leds, vez_jogador, ganhou, perdeu, pronto, vidas,
//                db_estado, db_rodada, db_timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module genius_controle_vidas #(
    parameter int NBOT     = 4,
    parameter int AW       = 4,
    parameter int T_MOSTRA = 1000,
    parameter int T_JOGADA = 5000,
    parameter int VIDAS    = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       iniciar,
    input  logic [NBOT-1:0]            botoes,
    input  logic                       modo2,
    input  logic [AW-1:0]              nivel_rodadas,
    input  logic [NBOT-1:0]            mem_rdata,
    output logic [AW-1:0]              mem_addr,
    output logic                       mem_we,
    output logic [NBOT-1:0]            mem_wdata,
    output logic [NBOT-1:0]            leds,
    output logic                       vez_jogador,
    output logic                       ganhou,
    output logic                       perdeu,
    output logic                       pronto,
    output logic [$clog2(VIDAS+1)-1:0] vidas,
    output logic [4:0]                 db_estado,
    output logic [AW-1:0]              db_rodada,
    output logic                       db_timeout
);

    localparam int c_vw  = $clog2(VIDAS + 1);
    localparam int c_tmw = (T_MOSTRA > 1) ? $clog2(T_MOSTRA) : 1;
    localparam int c_tjw = (T_JOGADA > 1) ? $clog2(T_JOGADA) : 1;

    localparam logic [c_tmw-1:0] c_tm_fim    = c_tmw'(T_MOSTRA - 1);
    localparam logic [c_tjw-1:0] c_tj_fim    = c_tjw'(T_JOGADA - 1);
    localparam logic [c_vw-1:0]  c_vidas_ini = c_vw'(VIDAS);
    localparam logic [c_vw-1:0]  c_vida_um   = c_vw'(1);

    localparam logic [4:0] c_st_inicial        = 5'h00;
    localparam logic [4:0] c_st_prepara        = 5'h01;
    localparam logic [4:0] c_st_inicio_rodada  = 5'h02;
    localparam logic [4:0] c_st_le_mostra      = 5'h03;
    localparam logic [4:0] c_st_mostra_aceso   = 5'h04;
    localparam logic [4:0] c_st_mostra_apagado = 5'h05;
    localparam logic [4:0] c_st_espera_jogada  = 5'h06;
    localparam logic [4:0] c_st_compara        = 5'h07;
    localparam logic [4:0] c_st_feedback       = 5'h08;
    localparam logic [4:0] c_st_espera_grav    = 5'h09;
    localparam logic [4:0] c_st_grava          = 5'h0A;
    localparam logic [4:0] c_st_proxima_rodada = 5'h0B;
    localparam logic [4:0] c_st_perde_vida     = 5'h0C;
    localparam logic [4:0] c_st_ganhou         = 5'h0D;
    localparam logic [4:0] c_st_perdeu         = 5'h0E;
    localparam logic [4:0] c_st_timeout        = 5'h0F;

    logic [4:0]       r_estado;
    logic [AW-1:0]    r_rodada;
    logic [AW-1:0]    r_endereco;
    logic [c_vw-1:0]  r_vidas;
    logic [c_tmw-1:0] r_tmostra;
    logic [c_tjw-1:0] r_tjogada;
    logic [NBOT-1:0]  r_jogada;
    logic             r_botoes_ativo;
    logic             r_modo2;
    logic [AW-1:0]    r_nivel;
    logic             r_acerto;
    logic             r_causa_to;

    logic w_evento;
    logic w_onehot;
    logic w_tm_fim;
    logic w_tj_fim;

    always_comb begin
        // A move exists only on the rising edge of "any button pressed", so a
        // button held across several waits is counted once.
        w_evento = (|botoes) & ~r_botoes_ativo;
        w_onehot = (r_jogada != '0) && ((r_jogada & (r_jogada - NBOT'(1))) == '0);
        w_tm_fim = (r_tmostra == c_tm_fim);
        w_tj_fim = (r_tjogada == c_tj_fim);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado       <= c_st_inicial;
            r_rodada       <= '0;
            r_endereco     <= '0;
            r_vidas        <= '0;
            r_tmostra      <= '0;
            r_tjogada      <= '0;
            r_jogada       <= '0;
            r_botoes_ativo <= 1'b0;
            r_modo2        <= 1'b0;
            r_nivel        <= '0;
            r_acerto       <= 1'b0;
            r_causa_to     <= 1'b0;
        end else begin
            r_botoes_ativo <= |botoes;
            case (r_estado)
                c_st_inicial: begin
                    if (iniciar) r_estado <= c_st_prepara;
                end
                c_st_prepara: begin
                    r_rodada   <= '0;
                    r_endereco <= '0;
                    r_vidas    <= c_vidas_ini;
                    r_modo2    <= modo2;
                    r_nivel    <= nivel_rodadas;
                    r_tmostra  <= '0;
                    r_estado   <= c_st_inicio_rodada;
                end
                c_st_inicio_rodada: begin
                    r_endereco <= '0;
                    if (w_tm_fim) begin
                        r_tmostra <= '0;
                        r_estado  <= c_st_le_mostra;
                    end else begin
                        r_tmostra <= r_tmostra + 1'b1;
                    end
                end
                // One idle cycle so the RAM read data is valid before lighting.
                c_st_le_mostra: begin
                    r_tmostra <= '0;
                    r_estado  <= c_st_mostra_aceso;
                end
                c_st_mostra_aceso: begin
                    if (w_tm_fim) begin
                        r_tmostra <= '0;
                        r_estado  <= c_st_mostra_apagado;
                    end else begin
                        r_tmostra <= r_tmostra + 1'b1;
                    end
                end
                c_st_mostra_apagado: begin
                    if (w_tm_fim) begin
                        r_tmostra <= '0;
                        if (r_endereco == r_rodada) begin
                            r_endereco <= '0;
                            r_tjogada  <= '0;
                            r_estado   <= c_st_espera_jogada;
                        end else begin
                            r_endereco <= r_endereco + AW'(1);
                            r_estado   <= c_st_le_mostra;
                        end
                    end else begin
                        r_tmostra <= r_tmostra + 1'b1;
                    end
                end
                // A move seen in the same cycle as the timer expiry wins.
                c_st_espera_jogada: begin
                    if (w_evento) begin
                        r_jogada <= botoes;
                        r_estado <= c_st_compara;
                    end else if (w_tj_fim) begin
                        r_causa_to <= 1'b1;
                        r_estado   <= c_st_perde_vida;
                    end else begin
                        r_tjogada <= r_tjogada + 1'b1;
                    end
                end
                // Non-one-hot moves are wrong even if they cover the right LED.
                c_st_compara: begin
                    r_acerto  <= w_onehot && (r_jogada == mem_rdata);
                    r_tmostra <= '0;
                    r_estado  <= c_st_feedback;
                end
                c_st_feedback: begin
                    if (w_tm_fim) begin
                        r_tmostra <= '0;
                        if (!r_acerto) begin
                            r_causa_to <= 1'b0;
                            r_estado   <= c_st_perde_vida;
                        end else if (r_endereco != r_rodada) begin
                            r_endereco <= r_endereco + AW'(1);
                            r_tjogada  <= '0;
                            r_estado   <= c_st_espera_jogada;
                        end else if (r_rodada == r_nivel) begin
                            r_estado <= c_st_ganhou;
                        end else if (r_modo2) begin
                            r_tjogada <= '0;
                            r_estado  <= c_st_espera_grav;
                        end else begin
                            r_estado <= c_st_proxima_rodada;
                        end
                    end else begin
                        r_tmostra <= r_tmostra + 1'b1;
                    end
                end
                c_st_espera_grav: begin
                    if (w_evento) begin
                        r_jogada <= botoes;
                        r_estado <= c_st_grava;
                    end else if (w_tj_fim) begin
                        r_causa_to <= 1'b1;
                        r_estado   <= c_st_perde_vida;
                    end else begin
                        r_tjogada <= r_tjogada + 1'b1;
                    end
                end
                c_st_grava: begin
                    r_estado <= c_st_proxima_rodada;
                end
                c_st_proxima_rodada: begin
                    r_rodada   <= r_rodada + AW'(1);
                    r_endereco <= '0;
                    r_tmostra  <= '0;
                    r_estado   <= c_st_inicio_rodada;
                end
                c_st_perde_vida: begin
                    r_vidas <= r_vidas - c_vida_um;
                    if (r_vidas != c_vida_um) begin
                        r_endereco <= '0;
                        r_tmostra  <= '0;
                        r_estado   <= c_st_inicio_rodada;
                    end else if (r_causa_to) begin
                        r_estado <= c_st_timeout;
                    end else begin
                        r_estado <= c_st_perdeu;
                    end
                end
                c_st_ganhou, c_st_perdeu, c_st_timeout: begin
                    if (iniciar) r_estado <= c_st_prepara;
                end
                default: r_estado <= c_st_inicial;
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        leds = '0;
        if (r_estado == c_st_mostra_aceso) leds = mem_rdata;
        if (r_estado == c_st_feedback)     leds = r_jogada;

        mem_addr = r_endereco;
        if ((r_estado == c_st_espera_grav) || (r_estado == c_st_grava))
            mem_addr = r_rodada + AW'(1);

        mem_we      = (r_estado == c_st_grava);
        mem_wdata   = r_jogada;
        vez_jogador = (r_estado == c_st_espera_jogada) || (r_estado == c_st_espera_grav);
        ganhou      = (r_estado == c_st_ganhou);
        perdeu      = (r_estado == c_st_perdeu) || (r_estado == c_st_timeout);
        pronto      = ganhou || perdeu;
        db_timeout  = (r_estado == c_st_timeout);
        vidas       = r_vidas;
        db_estado   = r_estado;
        db_rodada   = r_rodada;
    end

endmodule
`default_nettype wire
